// File: rtl/ms_stopwatch.sv
// ms_stopwatch: BCD mm:ss.mmm stopwatch fed by a 1 ms tick, with optional
// lap hold (define MS_STOPWATCH_LAP_EN to build the lap capture registers).
// Ports: clk, reset (sync, active-low), tick_1ms, start_stop, clear, lap in;
//   disp_min[7:0], disp_sec[7:0], disp_ms[11:0], running, full, lap_active out.
module ms_stopwatch #(
  parameter int MIN_MAX = 59
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_1ms,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        lap,
  output logic [7:0]  disp_min,
  output logic [7:0]  disp_sec,
  output logic [11:0] disp_ms,
  output logic        running,
  output logic        full,
  output logic        lap_active
);

  localparam logic [3:0] MAX_T = 4'(MIN_MAX / 10);
  localparam logic [3:0] MAX_U = 4'(MIN_MAX % 10);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_FULL
  } state_e;

  state_e      state_q;
  logic        running_q;
  logic        full_q;

  logic [7:0]  cnt_min_q;
  logic [7:0]  cnt_sec_q;
  logic [11:0] cnt_ms_q;
  logic [7:0]  cnt_min_d;
  logic [7:0]  cnt_sec_d;
  logic [11:0] cnt_ms_d;

  logic [7:0]  inc_min;
  logic [7:0]  inc_sec;
  logic [11:0] inc_ms;

  logic [7:0]  disp_min_q;
  logic [7:0]  disp_sec_q;
  logic [11:0] disp_ms_q;

  logic        at_max;
  logic        hold_q;
  logic        freeze;

  assign at_max = (cnt_min_q == {MAX_T, MAX_U})
               && (cnt_sec_q == 8'h59)
               && (cnt_ms_q == 12'h999);

  // Full BCD ripple in one cycle; minutes never pass MIN_MAX
  // because at_max blocks the increment.
  always_comb begin
    inc_ms  = cnt_ms_q;
    inc_sec = cnt_sec_q;
    inc_min = cnt_min_q;
    if (cnt_ms_q[3:0] != 4'd9) begin
      inc_ms[3:0] = cnt_ms_q[3:0] + 4'd1;
    end else begin
      inc_ms[3:0] = 4'd0;
      if (cnt_ms_q[7:4] != 4'd9) begin
        inc_ms[7:4] = cnt_ms_q[7:4] + 4'd1;
      end else begin
        inc_ms[7:4] = 4'd0;
        if (cnt_ms_q[11:8] != 4'd9) begin
          inc_ms[11:8] = cnt_ms_q[11:8] + 4'd1;
        end else begin
          inc_ms[11:8] = 4'd0;
          if (cnt_sec_q[3:0] != 4'd9) begin
            inc_sec[3:0] = cnt_sec_q[3:0] + 4'd1;
          end else begin
            inc_sec[3:0] = 4'd0;
            if (cnt_sec_q[7:4] != 4'd5) begin
              inc_sec[7:4] = cnt_sec_q[7:4] + 4'd1;
            end else begin
              inc_sec[7:4] = 4'd0;
              if (cnt_min_q[3:0] != 4'd9) begin
                inc_min[3:0] = cnt_min_q[3:0] + 4'd1;
              end else begin
                inc_min[3:0] = 4'd0;
                inc_min[7:4] = cnt_min_q[7:4] + 4'd1;
              end
            end
          end
        end
      end
    end
  end

  // Tick counts against the state at the start of the cycle, so a
  // tick alongside RUN->PAUSE still lands.
  always_comb begin
    cnt_min_d = cnt_min_q;
    cnt_sec_d = cnt_sec_q;
    cnt_ms_d  = cnt_ms_q;
    if (clear) begin
      cnt_min_d = 8'h00;
      cnt_sec_d = 8'h00;
      cnt_ms_d  = 12'h000;
    end else if (state_q == S_RUN && tick_1ms && !at_max) begin
      cnt_min_d = inc_min;
      cnt_sec_d = inc_sec;
      cnt_ms_d  = inc_ms;
    end
  end

`ifdef MS_STOPWATCH_LAP_EN
  logic hold_d;

  always_comb begin
    hold_d = hold_q;
    if (clear) begin
      hold_d = 1'b0;
    end else if (lap && state_q != S_IDLE) begin
      hold_d = !hold_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
    end
  end

  // Capture and release both load the live count; only a hold that
  // persists across the edge keeps the old display.
  assign freeze = hold_q & hold_d;
`else
  logic unused_lap;

  assign unused_lap = lap;
  assign hold_q     = 1'b0;
  assign freeze     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_min_q <= 8'h00;
      cnt_sec_q <= 8'h00;
      cnt_ms_q  <= 12'h000;
    end else begin
      cnt_min_q <= cnt_min_d;
      cnt_sec_q <= cnt_sec_d;
      cnt_ms_q  <= cnt_ms_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      disp_min_q <= 8'h00;
      disp_sec_q <= 8'h00;
      disp_ms_q  <= 12'h000;
    end else if (!freeze) begin
      disp_min_q <= cnt_min_d;
      disp_sec_q <= cnt_sec_d;
      disp_ms_q  <= cnt_ms_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      running_q <= 1'b0;
      full_q    <= 1'b0;
    end else if (clear) begin
      state_q   <= S_IDLE;
      running_q <= 1'b0;
      full_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_stop) begin
            state_q   <= S_RUN;
            running_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (start_stop) begin
            state_q   <= S_PAUSE;
            running_q <= 1'b0;
          end else if (tick_1ms && at_max) begin
            state_q   <= S_FULL;
            running_q <= 1'b0;
            full_q    <= 1'b1;
          end
        end
        S_PAUSE: begin
          if (start_stop) begin
            state_q   <= S_RUN;
            running_q <= 1'b1;
          end
        end
        S_FULL: begin
          state_q <= S_FULL;
        end
      endcase
    end
  end

  assign disp_min   = disp_min_q;
  assign disp_sec   = disp_sec_q;
  assign disp_ms    = disp_ms_q;
  assign running    = running_q;
  assign full       = full_q;
  assign lap_active = hold_q;

endmodule

// File: doc/ms_stopwatch.md
# ms_stopwatch

Millisecond-resolution stopwatch sitting directly downstream of the 1 ms tick generator: it consumes the single-cycle `tick_1ms` pulse and accumulates elapsed time as packed BCD minutes/seconds/milliseconds for the seven-segment display path. Start/stop and clear come from already-debounced single-cycle key pulses. An optional lap-hold feature freezes the displayed value while counting continues underneath.

## Interface
- `MIN_MAX`, default 59: highest minute value (BCD-counted, legal range 1..99); the count saturates at `MIN_MAX`:59.999.
- `clk`  in  1  system clock (50 MHz).
- `reset`  in  1  synchronous, active-low; clock `clk`.
- `tick_1ms`  in  1  one-cycle pulse, once per 1 ms, from the tick generator.
- `start_stop`  in  1  one-cycle pulse; toggles run/pause.
- `clear`  in  1  one-cycle pulse; zeroes the count and stops.
- `lap`  in  1  one-cycle pulse; toggles lap hold (ignored unless `LAP_EN`).
- `disp_min`  out  8  displayed minutes, two BCD digits.
- `disp_sec`  out  8  displayed seconds, two BCD digits (00..59).
- `disp_ms`  out  12  displayed milliseconds, three BCD digits (000..999).
- `running`  out  1  high in RUN.
- `full`  out  1  high in FULL (saturated).
- `lap_active`  out  1  high while the display is frozen (always 0 without `LAP_EN`).

## Operation
- States: IDLE (count zero, stopped), RUN, PAUSE, FULL. Reset value IDLE.
- IDLE --start_stop--> RUN; RUN --start_stop--> PAUSE; PAUSE --start_stop--> RUN; RUN --tick at max--> FULL; any state --clear--> IDLE. FULL ignores `start_stop` and `tick_1ms`.
- Count advances by one only on `tick_1ms` while in RUN. The state sampled is the state at the start of the cycle: a tick coincident with the RUN->PAUSE pulse is counted; a tick coincident with IDLE/PAUSE->RUN is not.
- BCD carry chain, all in one cycle: ms units 9->0 carries into tens, tens into hundreds, 999->000 into seconds, sec 59->00 into minutes.
- Tick when count is `MIN_MAX`:59.999: count holds at that value, state -> FULL, `running`=0, `full`=1.
- Priority in a single cycle: `reset` > `clear` > `start_stop` > `tick_1ms`. `clear` also drops lap hold.
- Live count and display registers are distinct; without lap hold the display equals the live count.
- No illegal BCD digit (>9) is ever produced on any output; sec tens never exceed 5.

## Timing
- All outputs registered. Reset values: all display digits 0, `running`=0, `full`=0, `lap_active`=0.
- Tick in cycle N -> updated display visible in cycle N+1 (1-cycle latency), including full carry ripple.
- `start_stop` in cycle N -> `running` changes in cycle N+1.
- `clear` in cycle N -> display 00:00.000, `running`=0, `full`=0 in cycle N+1, even mid-run or while FULL.
- `reset` low in any cycle overrides all inputs; state and outputs reach reset values the following cycle.
- Input pulses assumed one cycle wide; a level held high re-triggers every cycle (no edge detection inside the block).

## Configuration
- `MS_STOPWATCH_LAP_EN` defined: `lap` pulse with hold off captures the live count into the display registers and sets `lap_active`; the display then stays frozen while the live count continues. Next `lap` pulse releases the hold: display tracks the live count again from the next cycle. `lap` ignored in IDLE. Entering FULL while held keeps the hold.
- Not defined: `lap` input unused, `lap_active` tied 0, display always equals live count; no capture registers synthesized.

## Test plan
- Reset, then `start_stop`, 1234 ticks -> display 00:01.234, `running`=1; `start_stop`, 10 further ticks -> display unchanged 00:01.234, `running`=0.
- Preload by 59 999 ticks in RUN -> 00:59.999; one more tick -> 01:00.000 in the next cycle (full three-level carry).
- `MIN_MAX`=1, run to 01:59.999, tick -> display holds 01:59.999, `full`=1, `running`=0; `start_stop` -> no change; `clear` -> 00:00.000, `full`=0.
- Same-cycle `clear` + `start_stop` + `tick_1ms` while in RUN at 00:00.500 -> next cycle 00:00.000, IDLE, `running`=0.
- Same-cycle `start_stop` + tick in RUN at 00:00.007 -> 00:00.008, PAUSE; `reset` low mid-run -> all outputs zero next cycle.
- With `MS_STOPWATCH_LAP_EN`: run to 00:02.000, `lap`, 500 ticks -> display 00:02.000, `lap_active`=1; `lap` -> display 00:02.500 next cycle, `lap_active`=0.
